// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered position, syncs, visible-area flag and line/frame strobes.
// Optional VGA_TIMING_FRAME_COUNT_EN adds a 16-bit frame_count output.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] x_next;
    logic [9:0] y_next;

    always_comb begin
        x_next = DrawX + 10'd1;
        y_next = DrawY;
        if (DrawX == H_LAST) begin
            x_next = '0;
            y_next = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
        end
    end

    // Every output is decoded from the next position so all of them line up in the same cycle.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            DrawX       <= x_next;
            DrawY       <= y_next;
            hs          <= !((x_next >= HS_START) && (x_next < HS_END));
            vs          <= !((y_next >= VS_START) && (y_next < VS_END));
            blank       <= (x_next < H_VIS) && (y_next < V_VIS);
            line_start  <= (x_next == '0);
            frame_start <= (x_next == '0) && (y_next == '0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_COUNT_EN
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (frame_start) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced raster (15 x 10) so whole frames fit in a short run.
module tb_vga_timing_gen;

    // Reduced timing: H = 8+2+3+2 = 15, V = 6+1+2+1 = 10, frame = 150 cycles.
    // hs low for DrawX 10..12, vs low for DrawY 7..8, visible 8x6 = 48 cycles.
    logic       vga_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       pix_en  = 1'b0;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       line_start;
    logic       frame_start;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    int errors = 0;
    int checks = 0;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .hs         (hs),
        .vs         (vs),
        .blank      (blank),
        .line_start (line_start),
        .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    initial begin
        int hs_low, vs_low, vis, ls_cnt, fs_cnt, hs_bad, vs_bad, vis_bad, range_bad;

        // Reset state
        step();
        step();
        chk("rst_x", DrawX, 14);
        chk("rst_y", DrawY, 9);
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk("rst_blank", blank, 0);
        chk("rst_ls", line_start, 0);
        chk("rst_fs", frame_start, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        chk("rst_fc", frame_count, 0);
`endif

        // First enabled edge after release
        reset  = 1'b0;
        pix_en = 1'b1;
        step();
        chk("first_x", DrawX, 0);
        chk("first_y", DrawY, 0);
        chk("first_blank", blank, 1);
        chk("first_ls", line_start, 1);
        chk("first_fs", frame_start, 1);

        // One full frame: position against a cycle-index model, plus aggregate sync/visible counts
        hs_low = 0; vs_low = 0; vis = 0; ls_cnt = 0; fs_cnt = 0;
        hs_bad = 0; vs_bad = 0; vis_bad = 0; range_bad = 0;
        for (int i = 1; i <= 150; i++) begin
            step();
            chk("frame_x", DrawX, i % 15);
            chk("frame_y", DrawY, (i / 15) % 10);
            if (DrawX >= 15 || DrawY >= 10) range_bad++;
            if (!hs) begin
                hs_low++;
                if (DrawX < 10 || DrawX > 12) hs_bad++;
            end
            if (!vs) begin
                vs_low++;
                if (DrawY < 7 || DrawY > 8) vs_bad++;
            end
            if (blank) begin
                vis++;
                if (DrawX >= 8 || DrawY >= 6) vis_bad++;
            end
            if (line_start) ls_cnt++;
            if (frame_start) fs_cnt++;
            if (i == 90) chk("wrap_into_vblank_blank", blank, 0);
            if (i == 150) chk("frame_wrap_fs", frame_start, 1);
        end
        chk("hs_low_cycles", hs_low, 30);
        chk("hs_low_outside_window", hs_bad, 0);
        chk("vs_low_cycles", vs_low, 30);
        chk("vs_low_outside_window", vs_bad, 0);
        chk("visible_cycles", vis, 48);
        chk("visible_outside_area", vis_bad, 0);
        chk("line_start_count", ls_cnt, 10);
        chk("frame_start_count", fs_cnt, 1);
        chk("out_of_range_positions", range_bad, 0);

        // Freeze at the last visible pixel of line 1
        repeat (22) step();
        chk("pre_freeze_x", DrawX, 7);
        chk("pre_freeze_y", DrawY, 1);
        chk("pre_freeze_blank", blank, 1);
        pix_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("freeze_x", DrawX, 7);
            chk("freeze_y", DrawY, 1);
            chk("freeze_blank", blank, 1);
            chk("freeze_hs", hs, 1);
            chk("freeze_ls", line_start, 0);
            chk("freeze_fs", frame_start, 0);
        end
        pix_en = 1'b1;
        step();
        chk("unfreeze_x", DrawX, 8);
        chk("unfreeze_y", DrawY, 1);
        chk("unfreeze_blank", blank, 0);

        // Asynchronous reset in the middle of an hs pulse
        repeat (33) step();
        chk("pre_rst_x", DrawX, 11);
        chk("pre_rst_y", DrawY, 3);
        chk("pre_rst_hs", hs, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_hs", hs, 1);
        chk("async_rst_x", DrawX, 14);
        chk("async_rst_y", DrawY, 9);
        chk("async_rst_blank", blank, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        chk("async_rst_fc", frame_count, 0);
`endif
        step();
        reset = 1'b0;
        step();
        chk("restart_x", DrawX, 0);
        chk("restart_y", DrawY, 0);
        chk("restart_fs", frame_start, 1);

        // Three frames: frame_start period and frame counter
        for (int f = 1; f <= 3; f++) begin
            step();
            chk("post_fs_clear", frame_start, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
            chk("fc_after_fs", frame_count, f);
`endif
            repeat (149) step();
            chk("fs_period", frame_start, 1);
`ifdef VGA_TIMING_FRAME_COUNT_EN
            chk("fc_hold", frame_count, f);
`endif
        end

        // Strobe drops when enable goes low right after frame_start
        pix_en = 1'b0;
        step();
        chk("fs_drop_on_hold", frame_start, 0);
        chk("ls_drop_on_hold", line_start, 0);
        chk("hold_x", DrawX, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
